// File: rtl/cpu_trace_buffer.sv
// On-chip trace capture for the single-cycle computer: circular history of pc/im/regA/regB/ALU
// that freezes a programmable number of samples after a selectable trigger.
//
// state   | meaning
// IDLE    | no capture, waiting for arm
// ARMED   | writing every cycle, watching for the trigger
// CAPTURE | trigger seen, writing the post-trigger samples
// DONE    | frozen, history held for readback
module cpu_trace_buffer #(
  parameter int DATA_W      = 8,
  parameter int PC_W        = 4,
  parameter int IM_W        = 9,
  parameter int DEPTH       = 16,
  parameter int HALT_CYCLES = 4,
  localparam int AW         = $clog2(DEPTH),
  localparam int ENTRY_W    = PC_W + IM_W + 3 * DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic [1:0]         trig_mode,
  input  logic [DATA_W-1:0]  trig_value,
  input  logic [AW-1:0]      post_count,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [IM_W-1:0]    im_in,
  input  logic [DATA_W-1:0]  a_in,
  input  logic [DATA_W-1:0]  b_in,
  input  logic [DATA_W-1:0]  alu_in,
  input  logic [AW-1:0]      rd_addr,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [1:0]         state,
  output logic               done,
  output logic [AW:0]        valid_count,
  output logic [AW-1:0]      trig_offset,
  output logic [15:0]        cycle_count,
  output logic               halt_seen
);

  localparam int SW = $clog2(HALT_CYCLES + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(HALT_CYCLES - 1);
  localparam logic [SW-1:0] STALL_PRE = SW'(HALT_CYCLES - 2);
  localparam logic [AW:0]   VC_FULL   = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              st;
  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       post_q;
  logic [AW-1:0]       remaining;
  logic [1:0]          mode_q;
  logic [DATA_W-1:0]   value_q;
  logic [PC_W-1:0]     prev_pc;
  logic [SW-1:0]       stall_cnt;

  logic                running;
  logic                pc_eq;
  logic                halt_now;
  logic                trig_hit;
  logic [AW:0]         vc_next;
  logic [AW:0]         off_next;
  logic [AW-1:0]       rd_phys;
  logic [ENTRY_W-1:0]  sample;

  assign state = st;

  always_comb begin
    running  = (st == S_ARMED) || (st == S_CAPTURE);
    pc_eq    = (pc_in == prev_pc);
    // halt fires on the compare that brings the equal-run to HALT_CYCLES-1
    halt_now = running && pc_eq && (stall_cnt == STALL_PRE);
    case (mode_q)
      2'd0:    trig_hit = 1'b1;
      2'd1:    trig_hit = (alu_in == value_q);
      2'd2:    trig_hit = (pc_in == value_q[PC_W-1:0]);
      default: trig_hit = halt_now;
    endcase
    vc_next  = (valid_count == VC_FULL) ? valid_count : valid_count + 1'b1;
    off_next = vc_next - {1'b0, post_q} - 1'b1;
    rd_phys  = ((valid_count == VC_FULL) ? wr_ptr : '0) + rd_addr;
    sample   = {pc_in, im_in, a_in, b_in, alu_in};
  end

  always_ff @(posedge clk) begin
    if (running) mem[wr_ptr] <= sample;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= S_IDLE;
      wr_ptr      <= '0;
      valid_count <= '0;
      trig_offset <= '0;
      cycle_count <= '0;
      halt_seen   <= 1'b0;
      done        <= 1'b0;
      stall_cnt   <= '0;
      prev_pc     <= '0;
      mode_q      <= '0;
      value_q     <= '0;
      post_q      <= '0;
      remaining   <= '0;
      rd_data     <= '0;
    end else begin
      prev_pc <= pc_in;
      rd_data <= mem[rd_phys];
      case (st)
        S_IDLE, S_DONE: begin
          if (arm) begin
            mode_q      <= trig_mode;
            value_q     <= trig_value;
            post_q      <= post_count;
            wr_ptr      <= '0;
            valid_count <= '0;
            cycle_count <= '0;
            halt_seen   <= 1'b0;
            stall_cnt   <= '0;
            done        <= 1'b0;
            st          <= S_ARMED;
          end
        end
        S_ARMED, S_CAPTURE: begin
          wr_ptr      <= wr_ptr + 1'b1;
          valid_count <= vc_next;
          if (cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;
          if (!pc_eq)                      stall_cnt <= '0;
          else if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + 1'b1;
          if (halt_now) halt_seen <= 1'b1;
          if (st == S_ARMED) begin
            if (trig_hit) begin
              remaining <= post_q;
              if (post_q == '0) begin
                st          <= S_DONE;
                done        <= 1'b1;
                trig_offset <= off_next[AW-1:0];
              end else begin
                st <= S_CAPTURE;
              end
            end
          end else begin
            remaining <= remaining - 1'b1;
            if (remaining == AW'(1)) begin
              st          <= S_DONE;
              done        <= 1'b1;
              trig_offset <= off_next[AW-1:0];
            end
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
